request_unit: RTL and testbench
===============================

Name: request_unit

Overview:
- Memory-request sequencer directly downstream of the control unit in the single-cycle datapath.
- Consumes the decoded memRead/memWrite/halt of the current instruction.
- Drives instruction- and data-memory read/write enables toward the memory arbiter, and the PC-advance enable.
- Latches halt, counts retired instructions, and traps on a hung memory (hit never returns).

Parameters:
- TIMEOUT, 1024: cycles to wait for ihit/dhit before trapping. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- ihit  in  1  instruction memory access complete this cycle.
- dhit  in  1  data memory access complete this cycle.
- memRead  in  1  current instruction is a load (from control unit).
- memWrite  in  1  current instruction is a store (from control unit).
- halt  in  1  current instruction is HALT (from control unit).
- imemREN  out  1  instruction fetch request.
- dmemREN  out  1  data read request.
- dmemWEN  out  1  data write request.
- pcEn  out  1  one-cycle pulse: PC and register file commit the current instruction.
- halted  out  1  sticky, processor stopped.
- memTimeout  out  1  sticky, halt was caused by a timeout.
- instrCount  out  CNT_W  retired-instruction count.

Behaviour:
- State machine states: FETCH, DATA, HALTED. Registered state; outputs are a combinational decode of state and inputs.
- Reset values: on a CLK edge with RST=1, state=FETCH, waitCnt=0, instrCount=0, halted=0, memTimeout=0, and the latched rd/wr flags = 0.
  - While RST=1, all outputs are forced to 0.
  - imemREN first rises in the cycle after RST deasserts.
- FETCH:
  - imemREN=1, dmemREN=0, dmemWEN=0.
  - On ihit with halt=1: go to HALTED. pcEn=0; the halt instruction is not counted.
  - On ihit with memRead or memWrite: latch rdLat=memRead&~memWrite and wrLat=memWrite, then go to DATA. pcEn=0.
  - On ihit otherwise: pcEn=1, instrCount+1, stay in FETCH. Back-to-back non-memory instructions retire once per ihit cycle.
- DATA:
  - imemREN=0, dmemREN=rdLat, dmemWEN=wrLat. The PC is held, so the decoded instruction stays stable.
  - On dhit: pcEn=1, instrCount+1, go to FETCH. Latches clear.
  - ihit in DATA is ignored. If ihit and dhit arrive in the same cycle, only dhit is acted on.
- memRead and memWrite both high (illegal decode): write wins and no read is issued.
- halt has priority over memRead/memWrite when they are asserted together.
- HALTED:
  - All enables 0, pcEn=0, halted=1.
  - Only RST leaves this state; ihit/dhit are ignored.
- Timeout:
  - waitCnt increments each cycle in FETCH without ihit, or in DATA without dhit.
  - waitCnt clears on any hit and on every state change.
  - When waitCnt == TIMEOUT-1 and no hit arrives that cycle: set memTimeout=1 and go to HALTED. The trap is therefore taken after TIMEOUT consecutive missed cycles.
  - With TIMEOUT=0 the counter is never compared.
  - waitCnt width is $clog2(TIMEOUT+1), minimum 1.
- instrCount wraps modulo 2^CNT_W with no saturation.
- pcEn is never asserted in the same cycle as any transition into HALTED.
- RST mid-DATA: any outstanding request is dropped at the next edge. The arbiter must tolerate a request being abandoned.

Decomposition:
- Add reqstate_t (enum FETCH, DATA, HALTED) to cpu_types_pkg so the fetch/pipeline code can reuse it.
- Natural sub-module: wait_timer, a parameterised saturating miss counter with clear, enable and expired output, instantiated once.
- The rest stays in request_unit.

Test Plan:
- Reset, then ihit=1 every cycle, memRead=memWrite=halt=0 for 5 cycles -> pcEn=1 each cycle, instrCount=5, imemREN=1 throughout, dmemREN=dmemWEN=0.
- Load with memRead=1, ihit in cycle 1, dhit in cycle 4 -> imemREN=0 and dmemREN=1 in cycles 2-4. pcEn pulses only in cycle 4; instrCount +1; imemREN=1 in cycle 5.
- Store with memRead=memWrite=1 -> dmemWEN=1 and dmemREN=0 in DATA. ihit=dhit=1 together in DATA -> exactly one pcEn pulse, then FETCH.
- halt=1 and memRead=1 with ihit -> HALTED next cycle: halted=1, all enables 0, pcEn never pulses, instrCount unchanged. Later ihit/dhit toggling -> no change.
- TIMEOUT=8 in DATA with dhit held 0 -> memTimeout=1 and halted=1 exactly 8 cycles after entering DATA. A dhit on the 8th miss-candidate cycle -> normal retire, no trap.
- Assert RST for 1 cycle while in DATA with dmemREN=1 -> all outputs 0 during RST, instrCount=0, then imemREN=1 the next cycle. CNT_W=4 with 17 retires -> instrCount=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   reqstate_t : request sequencer state (FETCH, DATA, HALTED). The fetch and
//                pipeline logic reuse this type.
//   wait_w()   : width of a miss counter able to hold TIMEOUT, never below 1.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;

  function automatic int unsigned wait_w(input int unsigned t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Saturating miss counter.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : zero the count (takes priority over en)
//   en      : count one more missed cycle
//   expired : count has reached TIMEOUT-1; a further miss is the TIMEOUT-th
//             miss in a row. Never asserted when TIMEOUT == 0.
module wait_timer
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned W       = wait_w(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer for the single-cycle datapath.
// Turns decoded memRead/memWrite/halt into imem/dmem enables and a PC-commit
// pulse, latches halt, counts retired instructions and traps on a memory hit
// that never returns.
//   CLK, RST            : clock / synchronous active-high reset
//   ihit, dhit          : instruction / data access complete this cycle
//   memRead, memWrite   : current instruction is a load / store
//   halt                : current instruction is HALT
//   imemREN             : instruction fetch request
//   dmemREN, dmemWEN    : data read / write request
//   pcEn                : one-cycle commit pulse for PC and register file
//   halted, memTimeout  : sticky stop flag / stop was caused by a timeout
//   instrCount          : retired-instruction count, wraps
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             memRead,
  input  logic             memWrite,
  input  logic             halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pcEn,
  output logic             halted,
  output logic             memTimeout,
  output logic [CNT_W-1:0] instrCount
);

  reqstate_t        state_q, state_d;
  logic             rd_lat_q, rd_lat_d;
  logic             wr_lat_q, wr_lat_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic imem_ren, dmem_ren, dmem_wen, pc_en;
  logic hit, miss, expired;

  // Only the hit relevant to the current state matters; ihit in DATA is ignored.
  assign hit  = ((state_q == FETCH) && ihit) || ((state_q == DATA) && dhit);
  assign miss = ((state_q == FETCH) && !ihit) || ((state_q == DATA) && !dhit);

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (CLK),
    .rst     (RST),
    .clr     (hit || (state_d != state_q)),
    .en      (miss),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    rd_lat_d  = rd_lat_q;
    wr_lat_d  = wr_lat_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    imem_ren  = 1'b0;
    dmem_ren  = 1'b0;
    dmem_wen  = 1'b0;
    pc_en     = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_ren = 1'b1;
        if (ihit) begin
          if (halt) begin
            // halt beats any memory op and is not counted as retired
            state_d = HALTED;
          end else if (memRead || memWrite) begin
            // illegal read+write decode degrades to a plain store
            rd_lat_d = memRead && !memWrite;
            wr_lat_d = memWrite;
            state_d  = DATA;
          end else begin
            pc_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = HALTED;
        end
      end
      DATA: begin
        dmem_ren = rd_lat_q;
        dmem_wen = wr_lat_q;
        if (dhit) begin
          pc_en    = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          rd_lat_d = 1'b0;
          wr_lat_d = 1'b0;
          state_d  = FETCH;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = HALTED;
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      rd_lat_q  <= 1'b0;
      wr_lat_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rd_lat_q  <= rd_lat_d;
      wr_lat_q  <= wr_lat_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Everything is held quiet while reset is asserted, so an in-flight request
  // is dropped immediately.
  assign imemREN    = imem_ren && !RST;
  assign dmemREN    = dmem_ren && !RST;
  assign dmemWEN    = dmem_wen && !RST;
  assign pcEn       = pc_en && !RST;
  assign halted     = (state_q == HALTED) && !RST;
  assign memTimeout = timeout_q && !RST;
  assign instrCount = RST ? '0 : cnt_q;

endmodule

// File: tb/tb_request_unit.sv
module tb_request_unit;

  logic       CLK = 1'b0;
  logic       RST, ihit, dhit, memRead, memWrite, halt;
  logic       imemREN, dmemREN, dmemWEN, pcEn, halted, memTimeout;
  logic [3:0] instrCount;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  request_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .memRead(memRead), .memWrite(memWrite), .halt(halt),
    .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .pcEn(pcEn), .halted(halted), .memTimeout(memTimeout),
    .instrCount(instrCount)
  );

  // Advance to just after the next rising edge; inputs change here and
  // outputs are sampled #2 later, well away from either edge.
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; memRead = 0; memWrite = 0; halt = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
  endtask

  // Enter DATA with a load (rd=1) or store (rd=0)
  task automatic enter_data(input logic rd);
    ihit = 1; memRead = rd; memWrite = !rd;
    tick();
    ihit = 0;
  endtask

  task automatic test_reset();
    RST = 1; ihit = 1; dhit = 1; memRead = 1; memWrite = 0; halt = 0;
    tick(); tick(); #2;
    total++;
    if ({imemREN, dmemREN, dmemWEN, pcEn, halted, memTimeout} !== 6'b0) begin
      bad++; $display("FAIL reset_outs got=%b want=000000",
                      {imemREN, dmemREN, dmemWEN, pcEn, halted, memTimeout});
    end
    total++;
    if (instrCount !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", instrCount); end
    idle_inputs(); RST = 0; #1;
    total++;
    if (imemREN !== 1'b1) begin bad++; $display("FAIL reset_imem_rise got=%b want=1", imemREN); end
  endtask

  task automatic test_alu_run();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ihit = 1; #2;
      total++;
      if ({imemREN, pcEn, dmemREN, dmemWEN} !== 4'b1100) begin
        bad++; $display("FAIL alu_c%0d got=%b want=1100", i, {imemREN, pcEn, dmemREN, dmemWEN});
      end
      tick();
    end
    ihit = 0; #2;
    total++;
    if (instrCount !== 4'd5) begin bad++; $display("FAIL alu_cnt got=%0d want=5", instrCount); end
  endtask

  task automatic test_load();
    do_reset();
    ihit = 1; memRead = 1; #2;
    total++;
    if ({imemREN, pcEn} !== 2'b10) begin bad++; $display("FAIL load_c1 got=%b want=10", {imemREN, pcEn}); end
    tick(); ihit = 0;
    for (int c = 2; c <= 4; c++) begin
      dhit = (c == 4); #2;
      total++;
      if ({imemREN, dmemREN, dmemWEN, pcEn} !== {3'b010, (c == 4)}) begin
        bad++; $display("FAIL load_c%0d got=%b want=%b", c,
                        {imemREN, dmemREN, dmemWEN, pcEn}, {3'b010, (c == 4)});
      end
      tick();
    end
    idle_inputs(); #2;
    total++;
    if ({imemREN, dmemREN, pcEn, instrCount} !== {3'b100, 4'd1}) begin
      bad++; $display("FAIL load_c5 got=%b want=1000001", {imemREN, dmemREN, pcEn, instrCount});
    end
  endtask

  task automatic test_store_illegal();
    do_reset();
    ihit = 1; memRead = 1; memWrite = 1;
    tick();
    ihit = 1; dhit = 0; #2;  // ihit in DATA must be ignored
    total++;
    if ({imemREN, dmemREN, dmemWEN, pcEn} !== 4'b0010) begin
      bad++; $display("FAIL store_data got=%b want=0010", {imemREN, dmemREN, dmemWEN, pcEn});
    end
    dhit = 1; #1;
    total++;
    if (pcEn !== 1'b1) begin bad++; $display("FAIL store_both_hit got=%b want=1", pcEn); end
    tick();
    idle_inputs(); #2;
    total++;
    if ({imemREN, dmemWEN, pcEn, instrCount} !== {3'b100, 4'd1}) begin
      bad++; $display("FAIL store_after got=%b want=1000001", {imemREN, dmemWEN, pcEn, instrCount});
    end
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1; tick();  // one retire
    halt = 1; memRead = 1; #2;
    total++;
    if (pcEn !== 1'b0) begin bad++; $display("FAIL halt_pcen got=%b want=0", pcEn); end
    tick();
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); ihit = i[0]; dhit = !i[0]; #2;
      total++;
      if ({halted, memTimeout, imemREN, dmemREN, dmemWEN, pcEn, instrCount} !== {6'b100000, 4'd1}) begin
        bad++; $display("FAIL halt_hold%0d got=%b want=1000000001", i,
                        {halted, memTimeout, imemREN, dmemREN, dmemWEN, pcEn, instrCount});
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    // load hangs: trap exactly 8 cycles after the DATA entry edge
    do_reset();
    enter_data(1'b1);
    for (int i = 0; i < 8; i++) begin
      #2;
      total++;
      if ({halted, dmemREN} !== 2'b01) begin
        bad++; $display("FAIL tmo_wait%0d got=%b want=01", i, {halted, dmemREN});
      end
      tick();
    end
    #2;
    total++;
    if ({halted, memTimeout, dmemREN, pcEn} !== 4'b1100) begin
      bad++; $display("FAIL tmo_trap got=%b want=1100", {halted, memTimeout, dmemREN, pcEn});
    end
    // dhit on the last candidate cycle retires normally
    do_reset();
    enter_data(1'b0);
    for (int i = 0; i < 7; i++) tick();
    dhit = 1; #2;
    total++;
    if (pcEn !== 1'b1) begin bad++; $display("FAIL tmo_late_hit got=%b want=1", pcEn); end
    tick(); idle_inputs(); #2;
    total++;
    if ({halted, memTimeout, imemREN, instrCount} !== {3'b001, 4'd1}) begin
      bad++; $display("FAIL tmo_late_after got=%b want=0010001", {halted, memTimeout, imemREN, instrCount});
    end
    // fetch that never hits also traps
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    #2;
    total++;
    if ({halted, memTimeout, imemREN} !== 3'b110) begin
      bad++; $display("FAIL tmo_fetch got=%b want=110", {halted, memTimeout, imemREN});
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    ihit = 1; tick(); ihit = 0;   // count 1
    enter_data(1'b1); #2;
    total++;
    if (dmemREN !== 1'b1) begin bad++; $display("FAIL rstd_pre got=%b want=1", dmemREN); end
    RST = 1; #1;
    total++;
    if ({imemREN, dmemREN, dmemWEN, pcEn, halted, memTimeout, instrCount} !== 10'b0) begin
      bad++; $display("FAIL rstd_during got=%b want=0000000000",
                      {imemREN, dmemREN, dmemWEN, pcEn, halted, memTimeout, instrCount});
    end
    tick(); RST = 0; #2;
    total++;
    if ({imemREN, dmemREN, instrCount} !== {2'b10, 4'd0}) begin
      bad++; $display("FAIL rstd_after got=%b want=100000", {imemREN, dmemREN, instrCount});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    ihit = 1;
    for (int i = 0; i < 17; i++) tick();
    ihit = 0; #2;
    total++;
    if (instrCount !== 4'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want=1", instrCount); end
  endtask

  initial begin
    idle_inputs(); RST = 1;
    test_reset();
    test_alu_run();
    test_load();
    test_store_illegal();
    test_halt();
    test_timeout();
    test_reset_mid_data();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
